data_bus_arbiter: RTL

Two-master arbiter placed in front of the data-bus address decoder. It shares the single data bus (memory, LED register, switch input) between the CPU core load/store port (M0) and a debug/loader port (M1). Masters access the bus through a request/grant handshake, with round-robin fairness and optional bus locking. Responses are tracked through a fixed-latency pipeline so each read result returns to the master that issued it.

---
 rtl/data_bus_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin data-bus arbiter with a fixed-latency response pipeline.
// Define ARB_LOCK_EN to add the m0/m1 lock ports and the bus-ownership FSM.
//
// Lock FSM (ARB_LOCK_EN only):
//   state | meaning
//   IDLE  | plain round-robin between both masters
//   OWN0  | M0 holds the bus, M1 stalls
//   OWN1  | M1 holds the bus, M0 stalls
module data_bus_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_req_i,
   input  logic        m1_req_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m1_addr_i,
   input  logic        m0_write_i,
   input  logic        m1_write_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [31:0] m1_wdata_i,
`ifdef ARB_LOCK_EN
   input  logic        m0_lock_i,
   input  logic        m1_lock_i,
`endif
   output logic        m0_gnt_o,
   output logic        m1_gnt_o,
   output logic        m0_rvalid_o,
   output logic        m1_rvalid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] bus_addr_o,
   output logic        bus_write_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i
);

   logic                    last;
   logic                    gnt0_rr, gnt1_rr;
   logic                    gnt0, gnt1;
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_id;
   logic                    tail_valid, tail_id;

`ifdef ARB_LOCK_EN
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} lock_state_t;
   lock_state_t state_q, state_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt0 && m0_lock_i)      state_d = OWN0;
            else if (gnt1 && m1_lock_i) state_d = OWN1;
         end
         OWN0: if (!m0_req_i || (gnt0 && !m0_lock_i)) state_d = IDLE;
         OWN1: if (!m1_req_i || (gnt1 && !m1_lock_i)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
`endif

   // On contention the master that was not granted most recently wins.
   always_comb begin
      gnt0_rr = m0_req_i & (~m1_req_i | last);
      gnt1_rr = m1_req_i & (~m0_req_i | ~last);
`ifdef ARB_LOCK_EN
      if (state_q == OWN0) begin
         gnt0_rr = m0_req_i;
         gnt1_rr = 1'b0;
      end else if (state_q == OWN1) begin
         gnt0_rr = 1'b0;
         gnt1_rr = m1_req_i;
      end
`endif
   end

   // Grants are combinational, so they are masked while reset is held.
   assign gnt0     = gnt0_rr & rst_ni;
   assign gnt1     = gnt1_rr & rst_ni;
   assign m0_gnt_o = gnt0;
   assign m1_gnt_o = gnt1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   last <= 1'b1;
      else if (gnt0) last <= 1'b0;
      else if (gnt1) last <= 1'b1;
   end

   always_comb begin
      bus_addr_o  = '0;
      bus_write_o = 1'b0;
      bus_wdata_o = '0;
      if (gnt0) begin
         bus_addr_o  = m0_addr_i;
         bus_write_o = m0_write_i;
         bus_wdata_o = m0_wdata_i;
      end else if (gnt1) begin
         bus_addr_o  = m1_addr_i;
         bus_write_o = m1_write_i;
         bus_wdata_o = m1_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid <= '0;
         pipe_id    <= '0;
      end else begin
         pipe_valid[0] <= gnt0 | gnt1;
         pipe_id[0]    <= gnt1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   assign tail_valid  = pipe_valid[READ_LATENCY-1];
   assign tail_id     = pipe_id[READ_LATENCY-1];
   assign m0_rvalid_o = tail_valid & ~tail_id;
   assign m1_rvalid_o = tail_valid & tail_id;
   assign rdata_o     = tail_valid ? bus_rdata_i : 32'h0;

endmodule
